id_hazard_stall_unit: RTL and testbench
=======================================

Name: id_hazard_stall_unit

Overview:
- ID-stage hazard detector for the 5-stage MIPS32 pipeline; the stall/flush side of the EX-stage operand forwarding path.
- Covers the hazards forwarding cannot resolve: load-use, structural conflicts on the multi-cycle mult/div unit, and taken-branch flush.
- Drives PC write-enable, IF/ID write-enable, IF/ID flush and ID/EX flush (bubble insertion).
- Tracks mult/div occupancy with an FSM plus a down-counter.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is busy after issue; legal range 1..63.
- CNT_W, 6, busy-counter width; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_write_reg_addr  in  5  destination register of the instruction in EX
- if_id_instr_rs  in  5  rs field of the instruction in ID
- if_id_instr_rt  in  5  rt field of the instruction in ID
- if_id_uses_rt  in  1  ID instruction reads rt as a source (excludes I-type loads and ALU-immediate)
- id_md_start  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- id_uses_hilo  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID register load enable
- if_id_flush  out  1  zero the IF/ID register
- id_ex_flush  out  1  zero the ID/EX control bits (bubble)
- md_busy  out  1  mult/div unit occupied (registered)
- md_done  out  1  one-cycle pulse on the last busy cycle (registered)

Behaviour:
- States: IDLE and MD_BUSY, plus the down-counter cnt[CNT_W-1:0].
- Reset (asynchronous, rst=1):
  - state=IDLE, cnt=0, md_busy=0, md_done=0.
  - Combinational outputs take their no-hazard values: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0.
- load_use (combinational) = id_ex_mem_read & (id_ex_write_reg_addr!=0) & ((id_ex_write_reg_addr==if_id_instr_rs) | (if_id_uses_rt & id_ex_write_reg_addr==if_id_instr_rt)).
- md_conflict (combinational) = (state==MD_BUSY) & (id_md_start | id_uses_hilo).
- stall = (load_use | md_conflict) & ~ex_branch_taken.
- Output priority, evaluated every cycle:
  1. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1. The branch overrides any stall.
  2. stall: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0.
  3. Otherwise: pc_write=1, if_id_write=1, both flushes 0.
- Load-use stall lasts exactly 1 cycle. The bubble clears id_ex_mem_read on the next cycle; the load result then reaches the consumer through the MEM/WB forward.
- Issue (IDLE):
  - Condition: id_md_start & ~load_use & ~ex_branch_taken.
  - Next edge: state=MD_BUSY, cnt=MD_LATENCY-1, md_busy=1.
  - A flushed or stalled mult/div never issues.
- MD_BUSY:
  - cnt decrements each cycle.
  - When cnt==0: md_done=1 for that cycle only; next edge state=IDLE, md_busy=0.
  - Busy duration is exactly MD_LATENCY cycles. MD_LATENCY=1 gives one busy cycle with md_done asserted in it.
- Back-to-back: a mult/div waiting in ID during the md_done cycle still stalls. It issues on the following IDLE cycle; there is no same-cycle re-issue.
- A branch taken while MD_BUSY does not cancel the in-flight operation (it is already past EX). The counter continues.
- Reset mid-operation aborts the operation immediately: state=IDLE, md_busy=0, no md_done pulse.
- Register $0 never causes a load-use stall.
- No cycle ever has pc_write=0 together with if_id_flush=1.

Decomposition:
- Shared package mips_pipe_pkg:
  - state enum {IDLE, MD_BUSY};
  - REG_ZERO=5'd0;
  - control-output default constants (PC_WRITE_DEFAULT etc.) for reuse by the forwarding and control units.
- One natural sub-module, md_busy_tracker: FSM, cnt, md_busy and md_done; inputs issue and rst.
- Load-use and priority logic stay in the top module.

Test Plan:
- Load-use: EX = LW writing $5 (mem_read=1, dest=5); ID rs=5 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1. Repeat with dest=0 -> no stall. Repeat with rt=5 and uses_rt=0 -> no stall.
- Mult/div issue: MD_LATENCY=4; id_md_start pulsed in IDLE -> md_busy high for 4 cycles. md_done high only in the 4th. An MFHI held in ID stalls during all 4 cycles and advances in the cycle after md_done.
- Branch priority: load_use=1 and ex_branch_taken=1 in the same cycle -> pc_write=1, if_id_flush=1, id_ex_flush=1. Likewise, id_md_start with a taken branch -> no issue, md_busy stays 0.
- Branch during MD_BUSY: MD_LATENCY=8, branch taken at busy cycle 3 -> both flushes asserted that cycle. md_done still fires at cycle 8.
- Async reset: assert rst at busy cycle 2 between clock edges -> md_busy=0 immediately (same timestep). After release, no md_done pulse, and outputs are pc_write=1, flushes 0.
- Edge latency: MD_LATENCY=1 -> md_busy and md_done both high for exactly one cycle. A second id_md_start held in ID stalls that cycle and issues in the next.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types and constants for the ID-stage hazard, forwarding and control units.
package mips_pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Pipeline-advance controls driven by the hazard unit
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
    } hazard_ctrl_t;

    localparam logic PC_WRITE_DEFAULT    = 1'b1;
    localparam logic IF_ID_WRITE_DEFAULT = 1'b1;
    localparam logic IF_ID_FLUSH_DEFAULT = 1'b0;
    localparam logic ID_EX_FLUSH_DEFAULT = 1'b0;

    localparam hazard_ctrl_t CTRL_DEFAULT = '{
        pc_write:    PC_WRITE_DEFAULT,
        if_id_write: IF_ID_WRITE_DEFAULT,
        if_id_flush: IF_ID_FLUSH_DEFAULT,
        id_ex_flush: ID_EX_FLUSH_DEFAULT
    };

endpackage

// File: rtl/id_hazard_stall_unit_if.sv
// Hazard unit bundle: pipeline-state observations in, stall/flush controls out.
interface id_hazard_stall_unit_if;
    import mips_pipe_pkg::*;

    logic                  id_ex_mem_read;
    logic [REG_ADDR_W-1:0] id_ex_write_reg_addr;
    logic [REG_ADDR_W-1:0] if_id_instr_rs;
    logic [REG_ADDR_W-1:0] if_id_instr_rt;
    logic                  if_id_uses_rt;
    logic                  id_md_start;
    logic                  id_uses_hilo;
    logic                  ex_branch_taken;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  md_busy;
    logic                  md_done;

    modport master (
        output id_ex_mem_read, id_ex_write_reg_addr, if_id_instr_rs, if_id_instr_rt,
               if_id_uses_rt, id_md_start, id_uses_hilo, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, md_done
    );

    modport slave (
        input  id_ex_mem_read, id_ex_write_reg_addr, if_id_instr_rs, if_id_instr_rt,
               if_id_uses_rt, id_md_start, id_uses_hilo, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, md_done
    );

endinterface

// File: rtl/md_busy_tracker.sv
// Mult/div occupancy tracker: busy for MD_LATENCY cycles after issue, md_done on the last one.
module md_busy_tracker
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic md_busy,
    output logic md_done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    // md_done is raised on the edge that makes cnt reach zero, so it coincides with the last busy cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state   <= MD_BUSY;
                        cnt     <= CNT_LOAD;
                        md_busy <= 1'b1;
                        md_done <= (CNT_LOAD == '0);
                    end
                end
                MD_BUSY: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        md_busy <= 1'b0;
                        md_done <= 1'b0;
                    end else begin
                        cnt     <= cnt - CNT_W'(1);
                        md_done <= (cnt == CNT_W'(1));
                    end
                end
                default: begin
                    state   <= IDLE;
                    md_busy <= 1'b0;
                    md_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_hazard_stall_unit.sv
// ID-stage hazard detector: load-use and mult/div structural stalls, taken-branch flush.
module id_hazard_stall_unit
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    id_hazard_stall_unit_if.slave  hz
);

    logic         load_use;
    logic         md_conflict;
    logic         stall;
    logic         issue;
    hazard_ctrl_t ctrl;

    // $0 is hardwired, so a load targeting it never creates a dependency
    assign load_use = hz.id_ex_mem_read
                    & (hz.id_ex_write_reg_addr != REG_ZERO)
                    & ((hz.id_ex_write_reg_addr == hz.if_id_instr_rs)
                       | (hz.if_id_uses_rt & (hz.id_ex_write_reg_addr == hz.if_id_instr_rt)));

    assign md_conflict = hz.md_busy & (hz.id_md_start | hz.id_uses_hilo);
    assign stall       = (load_use | md_conflict) & ~hz.ex_branch_taken;
    assign issue       = hz.id_md_start & ~load_use & ~hz.ex_branch_taken;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_busy_tracker (
        .clk     (clk),
        .rst     (rst),
        .issue   (issue),
        .md_busy (hz.md_busy),
        .md_done (hz.md_done)
    );

    // Taken branch wins over any stall; pc_write stays high whenever IF/ID is flushed
    always_comb begin
        ctrl = CTRL_DEFAULT;
        if (hz.ex_branch_taken) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (stall) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.id_ex_flush = 1'b1;
        end
    end

    assign hz.pc_write    = ctrl.pc_write;
    assign hz.if_id_write = ctrl.if_id_write;
    assign hz.if_id_flush = ctrl.if_id_flush;
    assign hz.id_ex_flush = ctrl.id_ex_flush;

endmodule

// File: tb/tb_id_hazard_stall_unit.sv
// Directed bench for id_hazard_stall_unit; three instances (latency 4, 8, 1) share one stimulus.
module tb_id_hazard_stall_unit;

    // control word {pc_write, if_id_write, if_id_flush, id_ex_flush}
    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0001;
    localparam logic [3:0] C_BR    = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mr = 1'b0;
    logic [4:0] dest = 5'd0;
    logic [4:0] rs = 5'd0;
    logic [4:0] rt = 5'd0;
    logic       urt = 1'b0;
    logic       mds = 1'b0;
    logic       hilo = 1'b0;
    logic       br = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_hazard_stall_unit_if if4 ();
    id_hazard_stall_unit_if if8 ();
    id_hazard_stall_unit_if if1 ();

    always_comb begin
        if4.id_ex_mem_read = mr;  if8.id_ex_mem_read = mr;  if1.id_ex_mem_read = mr;
        if4.id_ex_write_reg_addr = dest; if8.id_ex_write_reg_addr = dest; if1.id_ex_write_reg_addr = dest;
        if4.if_id_instr_rs = rs;  if8.if_id_instr_rs = rs;  if1.if_id_instr_rs = rs;
        if4.if_id_instr_rt = rt;  if8.if_id_instr_rt = rt;  if1.if_id_instr_rt = rt;
        if4.if_id_uses_rt = urt;  if8.if_id_uses_rt = urt;  if1.if_id_uses_rt = urt;
        if4.id_md_start = mds;    if8.id_md_start = mds;    if1.id_md_start = mds;
        if4.id_uses_hilo = hilo;  if8.id_uses_hilo = hilo;  if1.id_uses_hilo = hilo;
        if4.ex_branch_taken = br; if8.ex_branch_taken = br; if1.ex_branch_taken = br;
    end

    id_hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(6)) u_dut4 (.clk(clk), .rst(rst), .hz(if4.slave));
    id_hazard_stall_unit #(.MD_LATENCY(8), .CNT_W(6)) u_dut8 (.clk(clk), .rst(rst), .hz(if8.slave));
    id_hazard_stall_unit #(.MD_LATENCY(1), .CNT_W(6)) u_dut1 (.clk(clk), .rst(rst), .hz(if1.slave));

    wire [3:0] c4 = {if4.pc_write, if4.if_id_write, if4.if_id_flush, if4.id_ex_flush};
    wire [3:0] c8 = {if8.pc_write, if8.if_id_write, if8.if_id_flush, if8.id_ex_flush};
    wire [3:0] c1 = {if1.pc_write, if1.if_id_write, if1.if_id_flush, if1.id_ex_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic m, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                          input logic u, input logic st, input logic h, input logic b);
        mr = m; dest = d; rs = s; rt = t; urt = u; mds = st; hilo = h; br = b;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_busy4", 32'(if4.md_busy), 32'd0);
        chk("rst_done4", 32'(if4.md_done), 32'd0);
        chk("rst_ctrl4", 32'(c4), 32'(C_RUN));
        tick();
        rst = 1'b0;

        // load-use on rs: one stall cycle, bubble clears mem_read next cycle
        set_in(1, 5, 5, 0, 0, 0, 0, 0); #4;
        chk("lu_rs_stall", 32'(c4), 32'(C_STALL));
        tick();
        set_in(0, 5, 5, 0, 0, 0, 0, 0); #4;
        chk("lu_after_bubble", 32'(c4), 32'(C_RUN));
        tick();
        set_in(1, 0, 0, 0, 1, 0, 0, 0); #4;
        chk("lu_reg0", 32'(c4), 32'(C_RUN));
        tick();
        set_in(1, 5, 3, 5, 0, 0, 0, 0); #4;
        chk("lu_rt_unused", 32'(c4), 32'(C_RUN));
        tick();
        set_in(1, 5, 3, 5, 1, 0, 0, 0); #4;
        chk("lu_rt_used", 32'(c4), 32'(C_STALL));
        tick();

        // branch priority over load-use; flushed mult/div does not issue
        set_in(1, 5, 5, 0, 0, 0, 0, 1); #4;
        chk("br_over_lu", 32'(c4), 32'(C_BR));
        tick();
        set_in(0, 0, 0, 0, 0, 1, 0, 1); #4;
        chk("br_md_ctrl", 32'(c4), 32'(C_BR));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); #4;
        chk("br_md_noissue", 32'(if4.md_busy), 32'd0);
        tick();
        set_in(1, 7, 7, 0, 0, 1, 0, 0); #4;
        chk("lu_md_stall", 32'(c4), 32'(C_STALL));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); #4;
        chk("lu_md_noissue", 32'(if4.md_busy), 32'd0);
        tick();

        // latency 4: issue, MFHI held in ID stalls all 4 busy cycles
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0, 0); #4;
        chk("md4_issue_ctrl", 32'(c4), 32'(C_RUN));
        chk("md4_pre_busy", 32'(if4.md_busy), 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            #4;
            chk($sformatf("md4_busy_c%0d", k), 32'(if4.md_busy), 32'd1);
            chk($sformatf("md4_done_c%0d", k), 32'(if4.md_done), 32'(k == 4));
            chk($sformatf("md4_hilo_c%0d", k), 32'(c4), 32'(C_STALL));
            tick();
        end
        #4;
        chk("md4_idle_busy", 32'(if4.md_busy), 32'd0);
        chk("md4_idle_done", 32'(if4.md_done), 32'd0);
        chk("md4_hilo_go", 32'(c4), 32'(C_RUN));
        tick();

        // latency 8: taken branch at busy cycle 3 does not cancel the operation
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, k == 3);
            #4;
            chk($sformatf("md8_busy_c%0d", k), 32'(if8.md_busy), 32'd1);
            chk($sformatf("md8_done_c%0d", k), 32'(if8.md_done), 32'(k == 8));
            if (k == 3) chk("md8_br_ctrl", 32'(c8), 32'(C_BR));
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0); #4;
        chk("md8_end_busy", 32'(if8.md_busy), 32'd0);
        tick();

        // async reset at busy cycle 2, between edges
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        #2;
        chk("ar_pre_busy", 32'(if4.md_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_busy_now", 32'(if4.md_busy), 32'd0);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            #4;
            chk($sformatf("ar_done_%0d", k), 32'(if4.md_done), 32'd0);
            chk($sformatf("ar_ctrl_%0d", k), 32'(c4), 32'(C_RUN));
        end
        tick();

        // latency 1: single busy+done cycle, back-to-back mult stalls once then issues
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0, 0); #4;
        chk("md1_issue_ctrl", 32'(c1), 32'(C_RUN));
        tick();
        #4;
        chk("md1_busy_a", 32'(if1.md_busy), 32'd1);
        chk("md1_done_a", 32'(if1.md_done), 32'd1);
        chk("md1_b2b_stall", 32'(c1), 32'(C_STALL));
        tick();
        #4;
        chk("md1_idle_busy", 32'(if1.md_busy), 32'd0);
        chk("md1_idle_done", 32'(if1.md_done), 32'd0);
        chk("md1_reissue_ctrl", 32'(c1), 32'(C_RUN));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); #4;
        chk("md1_busy_b", 32'(if1.md_busy), 32'd1);
        chk("md1_done_b", 32'(if1.md_done), 32'd1);
        tick();
        #4;
        chk("md1_end_busy", 32'(if1.md_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
